// File: rtl/gpcfg_mst_pkg.sv
// Shared constants and FSM encoding for gpcfg_cmd_master.
// The RMW states exist only when GPCFG_MST_RMW_EN is defined.
package gpcfg_mst_pkg;

  localparam logic [31:0] ADDR_STEP  = 32'd4;
  localparam int          RD_LAT_MAX = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RSP     = 3'd4
`ifdef GPCFG_MST_RMW_EN
    ,
    S_RMW_RD  = 3'd5,
    S_RMW_WR  = 3'd6
`endif
  } state_e;

endpackage

// File: rtl/gpcfg_mst_rsp_slice.sv
// One-entry response holding register; contents stay frozen until the
// valid/ready handshake and read as zero while empty.
module gpcfg_mst_rsp_slice (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        load,
  input  logic [31:0] load_rdata,
  input  logic        load_last,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last
);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_rdata;
      rsp_last  <= load_last;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/gpcfg_cmd_master.sv
// Command initiator for the gpcfg register-bank port: single/burst writes and reads.
// Optional read-modify-write support is compiled in with GPCFG_MST_RMW_EN.
module gpcfg_cmd_master
  import gpcfg_mst_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int RD_LAT = 0
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_rmw,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [31:0]      cmd_mask,
  input  logic [3:0]       cmd_be,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_last,
  output logic             wr_en,
  output logic             rd_en,
  output logic [3:0]       byte_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      rd_addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic             busy
);

  localparam int         LAT      = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [1:0] LAT_LAST = 2'(LAT);

  state_e           state, state_nxt;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [LEN_W-1:0] len_q, beat_q;
  logic [1:0]       lat_q;
  logic             last_beat, lat_done, rsp_hs;
  logic             rsp_load, rsp_load_last;
  logic [31:0]      rsp_load_rdata;

`ifdef GPCFG_MST_RMW_EN
  logic [31:0]      mask_q, old_q;
`else
  logic             unused_cfg;
  assign unused_cfg = ^{cmd_rmw, cmd_mask};
`endif

  assign last_beat = (beat_q == len_q);
  assign lat_done  = (lat_q == LAT_LAST);
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    rsp_load       = 1'b0;
    rsp_load_rdata = '0;
    rsp_load_last  = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    wr_addr        = '0;
    rd_addr        = '0;
    wdata          = '0;
    byte_en        = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_write) state_nxt = S_RD;
`ifdef GPCFG_MST_RMW_EN
          else if (cmd_rmw) state_nxt = S_RMW_RD;
`endif
          else state_nxt = S_WR;
        end
      end
      S_WR: begin
        wr_en   = 1'b1;
        wr_addr = addr_q;
        wdata   = wdata_q;
        byte_en = be_q;
        if (last_beat) begin
          rsp_load      = 1'b1;
          rsp_load_last = 1'b1;
          state_nxt     = S_RSP;
        end
      end
      // RD is the first cycle of a read beat; RD_WAIT covers the remaining latency.
      S_RD, S_RD_WAIT: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        if (lat_done) begin
          rsp_load       = 1'b1;
          rsp_load_rdata = rdata;
          rsp_load_last  = last_beat;
          state_nxt      = S_RSP;
        end else begin
          state_nxt = S_RD_WAIT;
        end
      end
      S_RSP: begin
        if (rsp_hs) state_nxt = rsp_last ? S_IDLE : S_RD;
      end
`ifdef GPCFG_MST_RMW_EN
      S_RMW_RD: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        if (lat_done) state_nxt = S_RMW_WR;
      end
      S_RMW_WR: begin
        wr_en          = 1'b1;
        wr_addr        = addr_q;
        wdata          = (old_q & ~mask_q) | (wdata_q & mask_q);
        byte_en        = 4'hF;
        rsp_load       = 1'b1;
        rsp_load_rdata = old_q;
        rsp_load_last  = 1'b1;
        state_nxt      = S_RSP;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
`ifdef GPCFG_MST_RMW_EN
      mask_q  <= '0;
      old_q   <= '0;
`endif
    end else begin
      lat_q <= (rd_en && !lat_done) ? lat_q + 2'd1 : 2'd0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= {cmd_addr[31:2], 2'b00};
            wdata_q <= cmd_wdata;
            be_q    <= cmd_be;
            len_q   <= cmd_len;
            beat_q  <= '0;
`ifdef GPCFG_MST_RMW_EN
            mask_q  <= cmd_mask;
`endif
          end
        end
        S_WR: begin
          addr_q <= addr_q + ADDR_STEP;
          beat_q <= beat_q + LEN_W'(1);
        end
        // Read beats advance only once the previous response has been taken.
        S_RSP: begin
          if (rsp_hs && !rsp_last) begin
            addr_q <= addr_q + ADDR_STEP;
            beat_q <= beat_q + LEN_W'(1);
          end
        end
`ifdef GPCFG_MST_RMW_EN
        S_RMW_RD: begin
          if (lat_done) old_q <= rdata;
        end
`endif
        default: ;
      endcase
    end
  end

  gpcfg_mst_rsp_slice u_rsp (
    .hclk       (hclk),
    .hreset     (hreset),
    .load       (rsp_load),
    .load_rdata (rsp_load_rdata),
    .load_last  (rsp_load_last),
    .rsp_ready  (rsp_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_last   (rsp_last)
  );

endmodule

// File: tb/tb_gpcfg_cmd_master.sv
// Bench for gpcfg_cmd_master: two instances (read latency 0 and 2), each with a bank model,
// checked against a transaction-level model of the expected bank beats and responses.
module tb_gpcfg_cmd_master;

  localparam int LAT0 = 0;
  localparam int LAT1 = 2;
`ifdef GPCFG_MST_RMW_EN
  localparam bit RMW_ON = 1'b1;
`else
  localparam bit RMW_ON = 1'b0;
`endif

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  logic [1:0]       c_valid, c_write, c_rmw, r_ready;
  logic [1:0][31:0] c_addr, c_wdata, c_mask;
  logic [1:0][3:0]  c_be, c_len;
  logic [1:0]       cmd_ready_s, rsp_valid_s, rsp_last_s, wr_en_s, rd_en_s, busy_s;
  logic [1:0][31:0] rsp_rdata_s, wr_addr_s, rd_addr_s, wdata_s, rdata_s;
  logic [1:0][3:0]  byte_en_s;
  int               rd_cnt1;
  int               n_chk = 0, n_pass = 0, n_fail = 0;

  function automatic logic [31:0] bank_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234_5678 : ~a;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Instance 0 bank answers combinationally; instance 1 only after LAT1 extra cycles of rd_en.
  assign rdata_s[0] = rd_en_s[0] ? bank_val(rd_addr_s[0]) : 32'hDEAD_BEEF;
  always @(posedge hclk or posedge hreset)
    if (hreset) rd_cnt1 <= 0;
    else        rd_cnt1 <= rd_en_s[1] ? rd_cnt1 + 1 : 0;
  assign rdata_s[1] = (rd_en_s[1] && rd_cnt1 >= LAT1) ? bank_val(rd_addr_s[1]) : 32'hDEAD_BEEF;

  gpcfg_cmd_master #(.LEN_W(4), .RD_LAT(LAT0)) dut0 (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(c_valid[0]), .cmd_ready(cmd_ready_s[0]), .cmd_write(c_write[0]), .cmd_rmw(c_rmw[0]),
    .cmd_addr(c_addr[0]), .cmd_wdata(c_wdata[0]), .cmd_mask(c_mask[0]), .cmd_be(c_be[0]), .cmd_len(c_len[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(r_ready[0]), .rsp_rdata(rsp_rdata_s[0]), .rsp_last(rsp_last_s[0]),
    .wr_en(wr_en_s[0]), .rd_en(rd_en_s[0]), .byte_en(byte_en_s[0]), .wr_addr(wr_addr_s[0]),
    .rd_addr(rd_addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .busy(busy_s[0])
  );

  gpcfg_cmd_master #(.LEN_W(4), .RD_LAT(LAT1)) dut1 (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(c_valid[1]), .cmd_ready(cmd_ready_s[1]), .cmd_write(c_write[1]), .cmd_rmw(c_rmw[1]),
    .cmd_addr(c_addr[1]), .cmd_wdata(c_wdata[1]), .cmd_mask(c_mask[1]), .cmd_be(c_be[1]), .cmd_len(c_len[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(r_ready[1]), .rsp_rdata(rsp_rdata_s[1]), .rsp_last(rsp_last_s[1]),
    .wr_en(wr_en_s[1]), .rd_en(rd_en_s[1]), .byte_en(byte_en_s[1]), .wr_addr(wr_addr_s[1]),
    .rd_addr(rd_addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .busy(busy_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command on instance d and follow it to its final response.
  // pre: command already presented by a chained predecessor; chain: present the same command
  // again in the cycle of the final handshake.
  task automatic run(input int d, input bit wr, input bit rmw, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] mk, input logic [3:0] be,
                     input int len, input int stall_beat, input int stall_n,
                     input bit pre, input bit chain);
    logic [31:0] ea[$], ed[$], era[$], ersp[$];
    logic [3:0]  ebe[$];
    bit          elast[$];
    logic [31:0] base, old, hold_d;
    logic        hold_l;
    bit          is_rmw, done, rsp_seen;
    int          n, wi, ri, pi, rd_run, last_rd, stall_left, viol, g, lat;
    base   = {a[31:2], 2'b00};
    n      = len + 1;
    lat    = lat_of(d);
    is_rmw = wr && rmw && RMW_ON;
    if (is_rmw) begin
      old = bank_val(base);
      era.push_back(base);
      ea.push_back(base); ed.push_back((old & ~mk) | (wd & mk)); ebe.push_back(4'hF);
      ersp.push_back(old); elast.push_back(1'b1);
    end else if (wr) begin
      for (int k = 0; k < n; k++) begin
        ea.push_back(base + 32'(4 * k)); ed.push_back(wd); ebe.push_back(be);
      end
      ersp.push_back(32'd0); elast.push_back(1'b1);
    end else begin
      for (int k = 0; k < n; k++) begin
        era.push_back(base + 32'(4 * k));
        ersp.push_back(bank_val(base + 32'(4 * k)));
        elast.push_back(k == n - 1);
      end
    end

    if (!pre) begin
      @(negedge hclk);
      c_write[d] = wr; c_rmw[d] = rmw; c_addr[d] = a; c_wdata[d] = wd;
      c_mask[d] = mk; c_be[d] = be; c_len[d] = 4'(len); c_valid[d] = 1'b1;
    end
    g = 0;
    while (!cmd_ready_s[d] && g < 20) begin @(negedge hclk); g++; end
    chk("cmd_ready", 32'(cmd_ready_s[d]), 32'd1);
    @(posedge hclk); #1;
    c_valid[d] = 1'b0;

    wi = 0; ri = 0; pi = 0; rd_run = 0; last_rd = -9; stall_left = 0; viol = 0;
    done = 1'b0; rsp_seen = 1'b0; hold_d = '0; hold_l = 1'b0;
    r_ready[d] = 1'b1;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge hclk);
      if (wr_en_s[d] && rd_en_s[d]) viol++;
      if (!wr_en_s[d] && (wr_addr_s[d] != 0 || wdata_s[d] != 0 || byte_en_s[d] != 0)) viol++;
      if (!rd_en_s[d] && rd_addr_s[d] != 0) viol++;
      if (cmd_ready_s[d] || !busy_s[d]) viol++;
      if (rsp_valid_s[d] && (wr_en_s[d] || rd_en_s[d])) viol++;
      if (wr_en_s[d]) begin
        if (wi < ea.size()) begin
          chk("wr_addr", wr_addr_s[d], ea[wi]);
          chk("wdata", wdata_s[d], ed[wi]);
          chk("byte_en", 32'(byte_en_s[d]), 32'(ebe[wi]));
          chk("wr_cycle", 32'(cyc), is_rmw ? 32'(lat + 2) : 32'(wi + 1));
        end else chk("extra_wr", 32'(wi + 1), 32'(ea.size()));
        wi++;
      end
      if (rd_en_s[d]) begin
        if (rd_run == 0) begin
          if (ri < era.size()) chk("rd_addr", rd_addr_s[d], era[ri]);
          else chk("extra_rd", 32'(ri + 1), 32'(era.size()));
          ri++;
        end
        rd_run++;
        last_rd = cyc;
      end
      if (rsp_valid_s[d]) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (pi < ersp.size()) begin
            chk("rsp_rdata", rsp_rdata_s[d], ersp[pi]);
            chk("rsp_last", 32'(rsp_last_s[d]), 32'(elast[pi]));
          end else chk("extra_rsp", 32'(pi + 1), 32'(ersp.size()));
          if (!wr) begin
            chk("rd_hold", 32'(rd_run), 32'(lat + 1));
            chk("rsp_after_rd", 32'(last_rd), 32'(cyc - 1));
          end else chk("rsp_cycle", 32'(cyc), is_rmw ? 32'(lat + 3) : 32'(n + 1));
          hold_d = rsp_rdata_s[d];
          hold_l = rsp_last_s[d];
          if (pi == stall_beat && stall_n > 0) begin
            r_ready[d] = 1'b0;
            stall_left = stall_n;
          end
        end else if (stall_left > 0) begin
          if (rsp_rdata_s[d] !== hold_d || rsp_last_s[d] !== hold_l) viol++;
          stall_left--;
          if (stall_left == 0) r_ready[d] = 1'b1;
        end
        if (r_ready[d]) begin
          if (rsp_last_s[d]) done = 1'b1;
          pi++;
          rsp_seen = 1'b0;
          rd_run = 0;
          if (done && chain) c_valid[d] = 1'b1;
        end
      end
    end
    chk("done", 32'(done), 32'd1);
    chk("n_wr", 32'(wi), 32'(ea.size()));
    chk("n_rd", 32'(ri), 32'(era.size()));
    chk("n_rsp", 32'(pi), 32'(ersp.size()));
    chk("protocol", 32'(viol), 32'd0);
    @(negedge hclk);
    chk("idle_ready", 32'(cmd_ready_s[d]), 32'd1);
    chk("idle_busy", 32'(busy_s[d]), 32'd0);
    chk("idle_rsp", 32'(rsp_valid_s[d]), 32'd0);
    if (chain) chk("chain_wait", 32'(wr_en_s[d] | rd_en_s[d]), 32'd0);
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_cmd_ready", 32'(cmd_ready_s[d]), 32'd1);
    chk("rst_busy", 32'(busy_s[d]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_s[d]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_s[d], 32'd0);
    chk("rst_rsp_last", 32'(rsp_last_s[d]), 32'd0);
    chk("rst_strobes", 32'({wr_en_s[d], rd_en_s[d]}), 32'd0);
    chk("rst_addrs", wr_addr_s[d] | rd_addr_s[d], 32'd0);
    chk("rst_wdata_be", wdata_s[d] | 32'(byte_en_s[d]), 32'd0);
  endtask

  initial begin
    int rv;
    hreset = 1'b1;
    c_valid = '0; c_write = '0; c_rmw = '0; r_ready = '1;
    c_addr = '0; c_wdata = '0; c_mask = '0; c_be = '0; c_len = '0;
    #12;
    for (int d = 0; d < 2; d++) chk_reset_outputs(d);
    @(negedge hclk); hreset = 1'b0;

    // single write, len 0
    run(0, 1'b1, 1'b0, 32'h10, 32'hA5A5_1234, 32'h0, 4'b0101, 0, -1, 0, 1'b0, 1'b0);
    // 3-beat reads at both latencies
    run(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4'h0, 2, -1, 0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4'h0, 2, -1, 0, 1'b0, 1'b0);
    // response stall on beat 0
    run(0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 4'h0, 1, 0, 5, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 4'h0, 1, 0, 5, 1'b0, 1'b0);
    // address wrap, write and read; unaligned address low bits ignored
    run(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0, 4'hF, 1, -1, 0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'h0, 32'h0, 4'h0, 2, 1, 2, 1'b0, 1'b0);
    // longest burst
    run(1, 1'b1, 1'b0, 32'h200, 32'h5555_AAAA, 32'h0, 4'b1010, 15, -1, 0, 1'b0, 1'b0);
    // read-modify-write (plain write when the feature is compiled out)
    run(0, 1'b1, 1'b1, 32'h40, 32'h0000_AB00, 32'h0000_FF00, 4'hF, 0, -1, 0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b1, 32'h40, 32'h0000_AB00, 32'h0000_FF00, 4'hF, 2, 0, 3, 1'b0, 1'b0);
    // new command presented in the cycle of the final handshake
    run(0, 1'b1, 1'b0, 32'h300, 32'hCAFE_0001, 32'h0, 4'h3, 0, -1, 0, 1'b0, 1'b1);
    run(0, 1'b1, 1'b0, 32'h300, 32'hCAFE_0001, 32'h0, 4'h3, 0, -1, 0, 1'b1, 1'b0);

    // reset in cycle 2 of a 4-beat write
    @(negedge hclk);
    c_write[0] = 1'b1; c_rmw[0] = 1'b0; c_addr[0] = 32'h100; c_wdata[0] = 32'h7777_0000;
    c_be[0] = 4'hF; c_len[0] = 4'd3; c_valid[0] = 1'b1;
    @(posedge hclk); #1; c_valid[0] = 1'b0;
    @(negedge hclk);
    chk("rst_pre_wr", 32'(wr_en_s[0]), 32'd1);
    @(posedge hclk); #2; hreset = 1'b1; #1;
    chk_reset_outputs(0);
    @(negedge hclk); hreset = 1'b0;
    rv = 0;
    repeat (6) begin
      @(negedge hclk);
      if (rsp_valid_s[0] || wr_en_s[0]) rv++;
    end
    chk("rst_no_rsp", 32'(rv), 32'd0);
    chk("rst_ready_after", 32'(cmd_ready_s[0]), 32'd1);

    // randomized commands on both instances
    for (int i = 0; i < 24; i++) begin
      int          d, len;
      logic [31:0] a;
      d   = i % 2;
      len = int'($urandom_range(0, 3));
      a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      run(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom,
          4'($urandom_range(0, 15)), len, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
